// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_ctrl_pkg : shared states and widths for the PC/branch sequencer   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package pc_ctrl_pkg;

    localparam int KEY_W         = 5;
    localparam int LUT_W         = 8;
    localparam int KEY_BR_LO_DEF = 16;
    localparam int KEY_BR_HI_DEF = 30;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BRANCH = 2'd2,
        ST_DONE   = 2'd3
    } pc_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_next_calc : sequential next-PC and wrap detection                 |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module pc_next_calc #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc,
    output logic            at_max
);

    assign pc_inc = pc + PC_W'(1);
    assign at_max = &pc;

endmodule
`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_branch_ctrl : fetch PC sequencer with external branch-target LUT  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module pc_branch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int START_PC  = 0,
    parameter int KEY_BR_LO = KEY_BR_LO_DEF,
    parameter int KEY_BR_HI = KEY_BR_HI_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             br_en,
    input  logic             br_taken,
    input  logic [KEY_W-1:0] br_key,
    output logic [KEY_W-1:0] lut_key,
    input  logic [LUT_W-1:0] lut_addr,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             busy,
    output logic             done,
    output logic             key_err,
    output logic             pc_ovf
);

    localparam logic [PC_W-1:0]  C_START_PC = START_PC[PC_W-1:0];
    localparam logic [KEY_W-1:0] C_KEY_LO   = KEY_BR_LO[KEY_W-1:0];
    localparam logic [KEY_W-1:0] C_KEY_HI   = KEY_BR_HI[KEY_W-1:0];

    pc_state_t        r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic [KEY_W-1:0] r_lut_key, w_lut_key_nxt;
    logic             r_key_err, w_key_err_nxt;
    logic             r_pc_ovf, w_pc_ovf_nxt;

    logic [PC_W-1:0]  w_pc_inc;
    logic             w_pc_at_max;
    logic             w_key_ok;
    logic             w_br_take;

    pc_next_calc #(
        .PC_W   (PC_W)
    ) u_next (
        .pc     (r_pc),
        .pc_inc (w_pc_inc),
        .at_max (w_pc_at_max)
    );

    assign w_key_ok  = (br_key >= C_KEY_LO) && (br_key <= C_KEY_HI);
    assign w_br_take = br_en && br_taken;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_lut_key_nxt = r_lut_key;
        w_key_err_nxt = r_key_err;
        w_pc_ovf_nxt  = r_pc_ovf;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt   = ST_RUN;
                    w_pc_nxt      = C_START_PC;
                    w_key_err_nxt = 1'b0;
                    w_pc_ovf_nxt  = 1'b0;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    w_state_nxt = ST_RUN;
                end else if (halt) begin
                    w_state_nxt = ST_DONE;
                end else if (w_br_take && w_key_ok) begin
                    w_lut_key_nxt = br_key;
                    w_state_nxt   = ST_BRANCH;
                end else begin
                    // A rejected key degrades to a not-taken branch
                    if (w_br_take) begin
                        w_key_err_nxt = 1'b1;
                    end
                    if (w_pc_at_max) begin
                        w_pc_ovf_nxt = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            ST_BRANCH: begin
                w_pc_nxt    = PC_W'(lut_addr);
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_lut_key <= '0;
            r_key_err <= 1'b0;
            r_pc_ovf  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_lut_key <= w_lut_key_nxt;
            r_key_err <= w_key_err_nxt;
            r_pc_ovf  <= w_pc_ovf_nxt;
        end
    end

    assign pc          = r_pc;
    assign lut_key     = r_lut_key;
    assign key_err     = r_key_err;
    assign pc_ovf      = r_pc_ovf;
    assign fetch_valid = (r_state == ST_RUN) && !stall;
    assign busy        = (r_state == ST_RUN) || (r_state == ST_BRANCH);
    assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_branch_ctrl : directed plus random bench with reference model  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_pc_branch_ctrl;

    localparam int PC_W   = 10;
    localparam int PC_MAX = (1 << PC_W) - 1;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_BR   = 2;
    localparam int M_DONE = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start, stall, halt, br_en, br_taken;
    logic [4:0]      br_key;
    logic [4:0]      lut_key;
    logic [7:0]      lut_addr;
    logic [PC_W-1:0] pc;
    logic            fetch_valid, busy, done, key_err, pc_ovf;

    logic [7:0] lut_mem [32];

    int n_checks = 0;
    int n_errors = 0;

    int m_mode, m_pc, m_key;
    bit m_kerr, m_ovf;

    always #5 clk = ~clk;

    assign lut_addr = lut_mem[lut_key];

    pc_branch_ctrl #(
        .PC_W        (PC_W),
        .START_PC    (0),
        .KEY_BR_LO   (16),
        .KEY_BR_HI   (30)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stall       (stall),
        .halt        (halt),
        .br_en       (br_en),
        .br_taken    (br_taken),
        .br_key      (br_key),
        .lut_key     (lut_key),
        .lut_addr    (lut_addr),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .busy        (busy),
        .done        (done),
        .key_err     (key_err),
        .pc_ovf      (pc_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = 0;
        m_key  = 0;
        m_kerr = 0;
        m_ovf  = 0;
    endtask

    // Advance the abstract machine by one clock using the inputs now applied
    task automatic model_clock();
        int nxt_mode;
        nxt_mode = m_mode;
        if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (start) begin
                nxt_mode = M_RUN;
                m_pc     = 0;
                m_kerr   = 0;
                m_ovf    = 0;
            end
        end else if (m_mode == M_BR) begin
            m_pc     = int'(lut_mem[m_key]);
            nxt_mode = M_RUN;
        end else if (!stall) begin
            if (halt) begin
                nxt_mode = M_DONE;
            end else if (br_en && br_taken && br_key >= 16 && br_key <= 30) begin
                m_key    = int'(br_key);
                nxt_mode = M_BR;
            end else begin
                if (br_en && br_taken) m_kerr = 1;
                if (m_pc + 1 > PC_MAX) begin
                    m_ovf    = 1;
                    nxt_mode = M_DONE;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
        end
        m_mode = nxt_mode;
    endtask

    task automatic check_outputs();
        check_eq("pc", 32'(pc), 32'(m_pc));
        check_eq("fetch_valid", 32'(fetch_valid), 32'((m_mode == M_RUN) && !stall));
        check_eq("busy", 32'(busy), 32'((m_mode == M_RUN) || (m_mode == M_BR)));
        check_eq("done", 32'(done), 32'(m_mode == M_DONE));
        check_eq("key_err", 32'(key_err), 32'(m_kerr));
        check_eq("pc_ovf", 32'(pc_ovf), 32'(m_ovf));
        check_eq("lut_key", 32'(lut_key), 32'(m_key));
    endtask

    task automatic step(input logic s, input logic st, input logic h,
                        input logic be, input logic bt, input logic [4:0] k);
        @(negedge clk);
        start = s; stall = st; halt = h; br_en = be; br_taken = bt; br_key = k;
        #1;
        check_outputs();
        model_clock();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic post_edge_check(input string tag, input logic [31:0] obs_sel, input logic [31:0] exp);
        check_eq(tag, obs_sel, exp);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) lut_mem[i] = 8'($urandom_range(0, 255));
        lut_mem[16] = 8'd2;
        lut_mem[17] = 8'd7;
        lut_mem[23] = 8'd154;
        lut_mem[30] = 8'd136;

        reset_n = 1'b0;
        start = 0; stall = 0; halt = 0; br_en = 0; br_taken = 0; br_key = 0;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Start and sequential stepping
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(posedge clk); #1;
        post_edge_check("start_pc", 32'(pc), 32'd0);
        post_edge_check("start_busy", 32'(busy), 32'd1);
        post_edge_check("start_fv", 32'(fetch_valid), 32'd1);
        repeat (3) idle_step();
        @(posedge clk); #1;
        post_edge_check("seq_pc3", 32'(pc), 32'd3);
        repeat (2) idle_step();

        // Taken branches through the LUT
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd16);
        @(posedge clk); #1;
        post_edge_check("br16_key", 32'(lut_key), 32'd16);
        post_edge_check("br16_bubble", 32'(fetch_valid), 32'd0);
        idle_step();
        @(posedge clk); #1;
        post_edge_check("br16_pc", 32'(pc), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd23);
        idle_step();
        @(posedge clk); #1;
        post_edge_check("br23_pc", 32'(pc), 32'd154);

        // Rejected key at pc 7
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd17);
        idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
        @(posedge clk); #1;
        post_edge_check("kerr_flag", 32'(key_err), 32'd1);
        post_edge_check("kerr_pc", 32'(pc), 32'd8);
        post_edge_check("kerr_busy", 32'(busy), 32'd1);
        repeat (2) idle_step();

        // Stall beats halt and branch; then halt beats branch
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd20);
        @(posedge clk); #1;
        post_edge_check("stall_pc", 32'(pc), 32'd10);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd20);
        @(posedge clk); #1;
        post_edge_check("halt_done", 32'(done), 32'd1);
        post_edge_check("halt_pc", 32'(pc), 32'd10);
        idle_step();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(posedge clk); #1;
        post_edge_check("restart_kerr", 32'(key_err), 32'd0);

        // Run up to the top of the address space
        for (int n = 0; n < 2000 && m_pc != PC_MAX; n++) idle_step();
        idle_step();
        @(posedge clk); #1;
        post_edge_check("ovf_flag", 32'(pc_ovf), 32'd1);
        post_edge_check("ovf_done", 32'(done), 32'd1);
        post_edge_check("ovf_pc", 32'(pc), 32'(PC_MAX));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(posedge clk); #1;
        post_edge_check("ovf_restart_pc", 32'(pc), 32'd0);
        post_edge_check("ovf_restart_flag", 32'(pc_ovf), 32'd0);

        // Reset while a key-30 load is pending
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd30);
        do_reset();
        repeat (3) idle_step();
        @(posedge clk); #1;
        post_edge_check("rst_no_load", 32'(pc), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < 6),
                     1'($urandom_range(0, 99) < 15),
                     1'($urandom_range(0, 99) < 3),
                     1'($urandom_range(0, 99) < 30),
                     1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 31)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
